sump_cmd_decoder: RTL and testbench
===================================

Name: sump_cmd_decoder

Overview:
- Receive-side counterpart of the metadata/ID transmit path in the SUMP-style logic-analyzer host link.
- Takes bytes from the UART receiver and frames them into SUMP commands: 1-byte short commands, or 5-byte long commands (an opcode with bit 7 set, followed by 4 data bytes).
- Issues control pulses (soft reset, arm) and long-command words for the capture core.
- Drives the begin_meta_transmit/send_id request into the metadata sender and tracks that sender to completion.

Parameters:
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one long command before the partial command is discarded (used only with the optional feature)
TMO_W, 20, width of the inter-byte timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYCLES

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
rx_byte  in  8  byte from UART receiver, valid when rx_valid=1
rx_valid  in  1  single-cycle strobe, one per received byte
meta_busy  in  1  busy status from metadata sender
cmd_valid  out  1  1-cycle pulse: long command complete
cmd_opcode  out  8  opcode of last long command, held until next cmd_valid
cmd_data  out  32  data of last long command, held until next cmd_valid
soft_reset  out  1  1-cycle pulse on short opcode 0x00
arm  out  1  1-cycle pulse on short opcode 0x01
begin_meta_transmit  out  1  request to metadata sender (level)
send_id  out  1  1 = ID request, 0 = metadata request; valid while begin_meta_transmit=1
overrun  out  1  sticky: a byte was dropped while a metadata transfer was in progress
timeout_err  out  1  1-cycle pulse when a partial long command is discarded (0 without the optional feature)

Behaviour:
- Reset: all outputs 0, cmd_opcode/cmd_data 0, byte counter 0, state IDLE.
- Reset has priority over every other event, including a mid-long-command or mid-metadata transfer. A partial command is lost.
- States: IDLE, COLLECT, META_REQ, META_WAIT.
- IDLE, rx_valid=1:
  - rx_byte[7]=1: latch opcode, clear byte count, go to COLLECT.
  - 0x00: soft_reset pulse. Also clears overrun.
  - 0x01: arm pulse.
  - 0x02: go to META_REQ with send_id=1.
  - 0x04: go to META_REQ with send_id=0.
  - Any other short opcode (including 0x11/0x13 flow control): ignored, stay IDLE.
- COLLECT, rx_valid=1:
  - Store the byte at position count (0..3), then increment count.
  - Data is little-endian: the first data byte goes to cmd_data[7:0], the fourth to cmd_data[31:24].
  - Data byte values are never interpreted; 0x00 inside COLLECT is data, not reset.
  - On the 4th data byte: update cmd_opcode/cmd_data, pulse cmd_valid, return to IDLE.
- Latency: rx_valid sampled in cycle k → soft_reset/arm/cmd_valid high in cycle k+1 only. begin_meta_transmit rises in cycle k+1.
- cmd_opcode/cmd_data change only in the cycle cmd_valid is asserted.
- META_REQ:
  - Hold begin_meta_transmit=1 and send_id stable.
  - When meta_busy=1 is sampled: drop begin_meta_transmit, go to META_WAIT.
- META_WAIT: when meta_busy=0 is sampled, go to IDLE. send_id returns to 0 on entering IDLE.
- Bytes in META_REQ/META_WAIT: rx_valid=1 drops the byte and sets overrun. overrun clears only on reset or an accepted 0x00 in IDLE.
- Simultaneous rx_valid and meta_busy edge in META_REQ/META_WAIT: the byte is still dropped, and the state transition still occurs.
- No byte is ever held pending; at most one byte is consumed per rx_valid.

Optional Feature:
- Macro: SUMP_CMD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to COLLECT and on each accepted byte, and increments every COLLECT cycle with rx_valid=0.
  - When it reaches TIMEOUT_CYCLES: discard the partial command (cmd_* unchanged), pulse timeout_err for 1 cycle, return to IDLE.
  - A byte arriving in the same cycle the counter reaches TIMEOUT_CYCLES is accepted, and the timeout does not fire.
- Not defined: no counter logic. COLLECT waits indefinitely. timeout_err is tied to 0.

Test Plan:
- Reset, then 0x01 then 0x00 → arm pulse 1 cycle after the first strobe, soft_reset 1 cycle after the second. No cmd_valid.
- Bytes 0x80,0x10,0x20,0x30,0x40 → single cmd_valid; cmd_opcode=0x80, cmd_data=0x40302010. Then bytes 0xC0,0x00,0x00,0x00,0x01 → cmd_data=0x01000000, and no soft_reset despite the 0x00 data bytes.
- 0x02 with a model that raises meta_busy 3 cycles later and holds it 20 cycles → begin_meta_transmit=1 and send_id=1 until meta_busy seen. IDLE after meta_busy falls. Repeat with 0x04 → send_id=0.
- During META_WAIT send 0x01 → no arm, overrun=1. Then, in IDLE, 0x00 → overrun=0.
- Send 0x82,0xAA, then assert reset_n=0 for 1 cycle, then 0x01 → no cmd_valid, arm pulses, state IDLE.
- With SUMP_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0x81,0x11, then idle 16 cycles → timeout_err pulse, cmd_* unchanged. Then send 0x01 → arm. Without the macro, the same stimulus plus 3 more bytes → cmd_valid with opcode 0x81.

Source files
------------

// File: rtl/sump_cmd_decoder.sv
// Purpose : frames UART bytes into SUMP short/long commands, drives the metadata sender request.
// Latency : byte sampled in cycle k -> soft_reset/arm/cmd_valid pulse and begin_meta_transmit in cycle k+1.
// Backpressure: none; bytes arriving while a metadata transfer is in flight are dropped and flagged by overrun.
//
// Ports:
//   clock, reset_n        rising-edge clock, synchronous active-low reset
//   rx_byte, rx_valid     received byte and its single-cycle strobe
//   meta_busy             busy status from the metadata sender
//   cmd_valid/opcode/data long-command pulse and held opcode/data word
//   soft_reset, arm       short-command pulses (0x00, 0x01)
//   begin_meta_transmit   level request to the metadata sender, send_id selects ID (1) or metadata (0)
//   overrun               sticky dropped-byte flag, cleared by reset or an accepted 0x00
//   timeout_err           partial long command discarded
// Optional feature: define SUMP_CMD_TIMEOUT_EN to enable the inter-byte timeout in COLLECT;
// without it COLLECT waits indefinitely and timeout_err is tied low.

module sump_cmd_decoder #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TMO_W          = 20
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic        meta_busy,
    output logic        cmd_valid,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        soft_reset,
    output logic        arm,
    output logic        begin_meta_transmit,
    output logic        send_id,
    output logic        overrun,
    output logic        timeout_err
);

    // The timeout counter must be able to hold TIMEOUT_CYCLES.
    if (TIMEOUT_CYCLES >= (1 << TMO_W)) begin : g_bad_tmo_w
        $error("sump_cmd_decoder: TMO_W too small for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_META_REQ,
        S_META_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;          // data bytes already stored in this long command
    logic [23:0] buf_q, buf_d;          // first three data bytes, little-endian
    logic [7:0]  op_q, op_d;            // opcode of the long command being collected
    logic [7:0]  cmd_opcode_q, cmd_opcode_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        soft_reset_q, soft_reset_d;
    logic        arm_q, arm_d;
    logic        send_id_q, send_id_d;
    logic        overrun_q, overrun_d;

`ifdef SUMP_CMD_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        op_d         = op_q;
        cmd_opcode_d = cmd_opcode_q;
        cmd_data_d   = cmd_data_q;
        cmd_valid_d  = 1'b0;
        soft_reset_d = 1'b0;
        arm_d        = 1'b0;
        send_id_d    = send_id_q;
        overrun_d    = overrun_q;
`ifdef SUMP_CMD_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_byte[7]) begin
                        op_d    = rx_byte;
                        cnt_d   = 2'd0;
                        state_d = S_COLLECT;
`ifdef SUMP_CMD_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end else begin
                        case (rx_byte)
                            8'h00: begin
                                soft_reset_d = 1'b1;
                                overrun_d    = 1'b0;
                            end
                            8'h01: arm_d = 1'b1;
                            8'h02: begin
                                state_d   = S_META_REQ;
                                send_id_d = 1'b1;
                            end
                            8'h04: begin
                                state_d   = S_META_REQ;
                                send_id_d = 1'b0;
                            end
                            default: ; // flow control and unknown short opcodes are ignored
                        endcase
                    end
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    // Data bytes are never interpreted, 0x00 here is plain data.
                    if (cnt_q == 2'd3) begin
                        cmd_data_d   = {rx_byte, buf_q};
                        cmd_opcode_d = op_q;
                        cmd_valid_d  = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        buf_d[{cnt_q, 3'b000} +: 8] = rx_byte;
                        cnt_d = cnt_q + 2'd1;
                    end
`ifdef SUMP_CMD_TIMEOUT_EN
                    tmo_d = '0;
                end else if (tmo_q == TMO_LIMIT) begin
                    // A byte in this very cycle would have won; none came, so drop the partial command.
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            S_META_REQ: begin
                if (rx_valid) overrun_d = 1'b1;
                if (meta_busy) state_d = S_META_WAIT;
            end
            S_META_WAIT: begin
                if (rx_valid) overrun_d = 1'b1;
                if (!meta_busy) begin
                    state_d   = S_IDLE;
                    send_id_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            buf_q        <= '0;
            op_q         <= '0;
            cmd_opcode_q <= '0;
            cmd_data_q   <= '0;
            cmd_valid_q  <= 1'b0;
            soft_reset_q <= 1'b0;
            arm_q        <= 1'b0;
            send_id_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            op_q         <= op_d;
            cmd_opcode_q <= cmd_opcode_d;
            cmd_data_q   <= cmd_data_d;
            cmd_valid_q  <= cmd_valid_d;
            soft_reset_q <= soft_reset_d;
            arm_q        <= arm_d;
            send_id_q    <= send_id_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef SUMP_CMD_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign cmd_valid           = cmd_valid_q;
    assign cmd_opcode          = cmd_opcode_q;
    assign cmd_data            = cmd_data_q;
    assign soft_reset          = soft_reset_q;
    assign arm                 = arm_q;
    assign begin_meta_transmit = (state_q == S_META_REQ);
    assign send_id             = send_id_q;
    assign overrun             = overrun_q;

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed scenarios then random transactions, every output
// compared each cycle against a transaction-level expectation model.

module tb_sump_cmd_decoder;

    localparam int TMO = 16;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic [7:0]  rx_byte   = 8'h00;
    logic        rx_valid  = 1'b0;
    logic        meta_busy = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        soft_reset;
    logic        arm;
    logic        begin_meta_transmit;
    logic        send_id;
    logic        overrun;
    logic        timeout_err;

    sump_cmd_decoder #(.TIMEOUT_CYCLES(TMO), .TMO_W(5)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .rx_byte             (rx_byte),
        .rx_valid            (rx_valid),
        .meta_busy           (meta_busy),
        .cmd_valid           (cmd_valid),
        .cmd_opcode          (cmd_opcode),
        .cmd_data            (cmd_data),
        .soft_reset          (soft_reset),
        .arm                 (arm),
        .begin_meta_transmit (begin_meta_transmit),
        .send_id             (send_id),
        .overrun             (overrun),
        .timeout_err         (timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // expected outputs for the cycle after the next clock edge
    bit          e_cmdv, e_srst, e_arm, e_tmo, e_bmt, e_sid, e_ovr;
    logic [7:0]  e_op;
    logic [31:0] e_data;
    // transaction-level model state
    bit          collecting, in_meta;
    logic [7:0]  lop;
    logic [31:0] acc;
    int          nb;
`ifdef SUMP_CMD_TIMEOUT_EN
    int          idle_run;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("cmd_valid", 32'(cmd_valid), 32'(e_cmdv));
        chk("cmd_opcode", 32'(cmd_opcode), 32'(e_op));
        chk("cmd_data", cmd_data, e_data);
        chk("soft_reset", 32'(soft_reset), 32'(e_srst));
        chk("arm", 32'(arm), 32'(e_arm));
        chk("begin_meta", 32'(begin_meta_transmit), 32'(e_bmt));
        chk("send_id", 32'(send_id), 32'(e_sid));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("timeout_err", 32'(timeout_err), 32'(e_tmo));
        e_cmdv = 0; e_srst = 0; e_arm = 0; e_tmo = 0;
    endtask

    task automatic model_clear();
        e_cmdv = 0; e_srst = 0; e_arm = 0; e_tmo = 0; e_bmt = 0; e_sid = 0; e_ovr = 0;
        e_op = 8'h00; e_data = 32'h0;
        collecting = 0; in_meta = 0; nb = 0; acc = 32'h0; lop = 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        tick();
        reset_n = 1'b1;
    endtask

    // one cycle with no byte; a partial long command dies after TMO silent cycles
    task automatic idle_tick();
`ifdef SUMP_CMD_TIMEOUT_EN
        if (collecting) begin
            if (idle_run == TMO) begin
                collecting = 0;
                e_tmo = 1;
            end else begin
                idle_run++;
            end
        end
`endif
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        if (in_meta) begin
            e_ovr = 1;
        end else if (collecting) begin
            acc[8*nb +: 8] = b;
            nb++;
`ifdef SUMP_CMD_TIMEOUT_EN
            idle_run = 0;
`endif
            if (nb == 4) begin
                e_op = lop; e_data = acc; e_cmdv = 1; collecting = 0;
            end
        end else if (b[7]) begin
            collecting = 1; lop = b; nb = 0; acc = 32'h0;
`ifdef SUMP_CMD_TIMEOUT_EN
            idle_run = 0;
`endif
        end else begin
            case (b)
                8'h00: begin e_srst = 1; e_ovr = 0; end
                8'h01: e_arm = 1;
                8'h02: begin in_meta = 1; e_bmt = 1; e_sid = 1; end
                8'h04: begin in_meta = 1; e_bmt = 1; e_sid = 0; end
                default: ;
            endcase
        end
        tick();
        rx_valid = 1'b0;
    endtask

    // busy handshake after a metadata request; inj allows dropped bytes in any cycle
    task automatic meta_phase(input int gap, input int hold, input bit inj);
        for (int i = 0; i < gap; i++) begin
            if (inj && $urandom_range(0, 2) == 0) send_byte(8'($urandom));
            else idle_tick();
        end
        meta_busy = 1'b1;
        e_bmt = 0;
        if (inj && $urandom_range(0, 2) == 0) begin
            rx_byte = 8'($urandom); rx_valid = 1'b1; e_ovr = 1;
        end
        tick();
        rx_valid = 1'b0;
        for (int i = 1; i < hold; i++) begin
            if (inj && $urandom_range(0, 3) == 0) send_byte(8'($urandom));
            else idle_tick();
        end
        meta_busy = 1'b0;
        e_sid = 0;
        if (inj && $urandom_range(0, 2) == 0) begin
            rx_byte = 8'($urandom); rx_valid = 1'b1; e_ovr = 1;
        end
        tick();
        rx_valid = 1'b0;
        in_meta = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        do_reset();

        // short commands
        send_byte(8'h01); idle_tick();
        send_byte(8'h00); idle_tick();

        // long commands, little-endian data, 0x00 data bytes are not soft reset
        send_byte(8'h80); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        chk("long1_data_const", cmd_data, 32'h40302010);
        idle_tick();
        send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        chk("long2_data_const", cmd_data, 32'h01000000);
        idle_tick();

        // metadata requests: ID then metadata
        send_byte(8'h02); meta_phase(3, 20, 1'b0);
        send_byte(8'h04); meta_phase(3, 20, 1'b0);

        // byte during META_WAIT is dropped, 0x00 later clears overrun
        send_byte(8'h02); idle_tick();
        meta_busy = 1'b1; e_bmt = 0; tick();
        send_byte(8'h01); idle_tick(); idle_tick();
        meta_busy = 1'b0; e_sid = 0; tick(); in_meta = 0;
        send_byte(8'h00); idle_tick();

        // reset in the middle of a long command
        send_byte(8'h82); send_byte(8'hAA);
        do_reset();
        send_byte(8'h01); idle_tick();

        // reset in the middle of a metadata transfer
        send_byte(8'h02); idle_tick();
        meta_busy = 1'b1; e_bmt = 0; tick();
        do_reset();
        meta_busy = 1'b0; idle_tick();
        send_byte(8'h01); idle_tick();

        // inter-byte silence: longer than the limit, then exactly at the limit
        send_byte(8'h81); send_byte(8'h11);
        repeat (TMO + 1) idle_tick();
`ifdef SUMP_CMD_TIMEOUT_EN
        send_byte(8'h01);
`else
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`endif
        idle_tick();
        send_byte(8'h83);
        for (int i = 0; i < 4; i++) begin
            repeat (TMO) idle_tick();
            send_byte(8'(8'h50 + i));
        end
        idle_tick();

        // random traffic
        for (int t = 0; t < 200; t++) begin
            int sel;
            sel = $urandom_range(0, 19);
            if (sel < 7) begin
                logic [7:0] b;
                case ($urandom_range(0, 4))
                    0: b = 8'h00;
                    1: b = 8'h01;
                    2: b = 8'h11;
                    3: b = 8'h13;
                    default: b = 8'($urandom_range(0, 127));
                endcase
                if (b == 8'h02 || b == 8'h04) b = 8'h05;
                send_byte(b);
            end else if (sel < 13) begin
                send_byte(8'h80 | 8'($urandom_range(0, 127)));
                for (int i = 0; i < 4; i++) begin
                    int g;
                    g = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
                    repeat (g) idle_tick();
                    send_byte(8'($urandom));
                end
            end else if (sel < 19) begin
                send_byte(($urandom_range(0, 1) == 1) ? 8'h02 : 8'h04);
                meta_phase($urandom_range(0, 4), $urandom_range(1, 8), 1'b1);
            end else begin
                do_reset();
            end
            repeat ($urandom_range(0, 3)) idle_tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
